// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, 16x-oversampled mid-bit deframing,
// single-entry valid/ready holding register with frame/parity/overrun flags.
// Ports: clk_i, rst_ni, baud_en_i, rx_i -> rx_data_o, rx_valid_o, rx_ready_i,
//        rx_frame_err_o, rx_parity_err_o, rx_overrun_o.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 baud_en_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_overrun_o
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
  localparam logic PEN = (PARITY_EN != 0);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 done;
  logic                 rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= 2'b11;
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    ovr_d     = 1'b0;
    done      = 1'b0;

    if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end

    if (baud_en_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == HALF) begin
            tick_d  = '0;
            bit_d   = '0;
            // line back high at mid start bit: glitch
            state_d = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BLAST) begin
              state_d = PEN ? S_PARITY : S_STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_q == LAST) begin
            tick_d    = '0;
            par_err_d = rx_s ^ (^shift_q) ^ ODD;
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_q == LAST) begin
            tick_d  = '0;
            state_d = S_IDLE;
            done    = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      endcase
    end

    if (done) begin
      if (!valid_q || rx_ready_i) begin
        data_d  = shift_q;
        ferr_d  = !rx_s;
        perr_d  = PEN & par_err_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data_o       = data_q;
  assign rx_valid_o      = valid_q;
  assign rx_frame_err_o  = ferr_q;
  assign rx_parity_err_o = perr_q;
  assign rx_overrun_o    = ovr_q;

endmodule
